// File: rtl/idct_pkg.sv
// Shared widths, Q1.12 Loeffler constants and the final round/saturate helper for the 8x8 IDCT.
// IDCT_CLAMP_EN selects saturation of the final result; without it the low 8 bits wrap.
package idct_pkg;
  localparam int COEF_W      = 12;
  localparam int PIX_W       = 8;
  localparam int MID_W       = 20;  // row-pass result, 3 fraction bits
  localparam int ACC_W       = 38;  // column-pass accumulator, 15 fraction bits
  localparam int Q_BITS      = 12;
  localparam int ROW_SHIFT   = 9;   // drops Q12 down to 3 fraction bits
  localparam int FINAL_SHIFT = 18;  // 3 (1/8) + 12 (Q12) + 3 (row fraction)

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PIX_W-1:0]  pix_t;
  typedef logic signed [MID_W-1:0]  mid_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [15:0]       cst_t;

  typedef logic [7:0][7:0][COEF_W-1:0] coef_blk_t;
  typedef logic [7:0][7:0][MID_W-1:0]  mid_blk_t;
  typedef logic [7:0][7:0][ACC_W-1:0]  acc_blk_t;
  typedef logic [7:0][7:0][PIX_W-1:0]  pix_blk_t;

  localparam cst_t C1_Q    = 16'sd4017;  // cos(pi/16)
  localparam cst_t S1_Q    = 16'sd799;
  localparam cst_t C3_Q    = 16'sd3406;  // cos(3pi/16)
  localparam cst_t S3_Q    = 16'sd2276;
  localparam cst_t C6_Q    = 16'sd1567;  // cos(6pi/16)
  localparam cst_t S6_Q    = 16'sd3784;
  localparam cst_t SQRT2_Q = 16'sd5793;

  // Multipliers with the sqrt(2) of the odd and even rotations folded in.
  localparam cst_t K_C1 = cst_t'((int'(SQRT2_Q) * int'(C1_Q) + 2048) >>> Q_BITS);
  localparam cst_t K_S1 = cst_t'((int'(SQRT2_Q) * int'(S1_Q) + 2048) >>> Q_BITS);
  localparam cst_t K_C3 = cst_t'((int'(SQRT2_Q) * int'(C3_Q) + 2048) >>> Q_BITS);
  localparam cst_t K_S3 = cst_t'((int'(SQRT2_Q) * int'(S3_Q) + 2048) >>> Q_BITS);
  localparam cst_t K_C6 = cst_t'((int'(SQRT2_Q) * int'(C6_Q) + 2048) >>> Q_BITS);
  localparam cst_t K_S6 = cst_t'((int'(SQRT2_Q) * int'(S6_Q) + 2048) >>> Q_BITS);

  localparam acc_t ROUND_OFS     = acc_t'(64'sd1 <<< (FINAL_SHIFT - 1));
  localparam acc_t ROUND_OFS_NEG = ROUND_OFS - acc_t'(1);  // makes negative ties round away from zero

  function automatic pix_t round_pix(input acc_t v);
`ifdef IDCT_CLAMP_EN
    acc_t r;
    r = (v + (v[ACC_W-1] ? ROUND_OFS_NEG : ROUND_OFS)) >>> FINAL_SHIFT;
    if (r > acc_t'(127))
      return 8'sd127;
    else if (r < acc_t'(-128))
      return -8'sd128;
    else
      return pix_t'(r);
`else
    return pix_t'((v + (v[ACC_W-1] ? ROUND_OFS_NEG : ROUND_OFS)) >>> FINAL_SHIFT);
`endif
  endfunction
endpackage

// File: rtl/loeffler1d_idct.sv
// Combinational 8-point Loeffler IDCT: y[n] = x0 + sqrt2 * sum x[k] cos((2n+1)k pi/16), scaled by Q12,
// then a rounded right shift by SHIFT. Input index is frequency k, output index is sample n.
module loeffler1d_idct
  import idct_pkg::*;
#(
  parameter int IW    = 12,
  parameter int OW    = 20,
  parameter int SHIFT = 9
) (
  input  logic [7:0][IW-1:0] x,
  output logic [7:0][OW-1:0] y
);
  localparam int W = IW + 18;
  localparam logic signed [W-1:0] RND = W'((64'sd1 <<< SHIFT) >>> 1);
  localparam logic signed [W-1:0] MC1 = W'(K_C1);
  localparam logic signed [W-1:0] MS1 = W'(K_S1);
  localparam logic signed [W-1:0] MC3 = W'(K_C3);
  localparam logic signed [W-1:0] MS3 = W'(K_S3);
  localparam logic signed [W-1:0] MC6 = W'(K_C6);
  localparam logic signed [W-1:0] MS6 = W'(K_S6);

  logic signed [W-1:0] xs [8];
  logic signed [W-1:0] e  [4];
  logic signed [W-1:0] o  [4];
  logic signed [W-1:0] g  [8];
  logic signed [W-1:0] a0, a1, b0, b1;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ext
      assign xs[gi] = W'($signed(x[gi]));
    end
  endgenerate

  always_comb begin
    // Even half: DC/x4 butterfly plus the 6pi/16 rotation of x2/x6.
    a0 = (xs[0] + xs[4]) <<< Q_BITS;
    a1 = (xs[0] - xs[4]) <<< Q_BITS;
    b0 = MS6 * xs[2] + MC6 * xs[6];
    b1 = MC6 * xs[2] - MS6 * xs[6];
    e[0] = a0 + b0;
    e[1] = a1 + b1;
    e[2] = a1 - b1;
    e[3] = a0 - b0;
    // Odd half: (x1,x7) and (x3,x5) rotated by pi/16 and 3pi/16.
    o[0] = MC1 * xs[1] + MS1 * xs[7] + MC3 * xs[3] + MS3 * xs[5];
    o[1] = MC3 * xs[1] - MS3 * xs[7] - MS1 * xs[3] - MC1 * xs[5];
    o[2] = MS3 * xs[1] + MC3 * xs[7] - MC1 * xs[3] + MS1 * xs[5];
    o[3] = MS1 * xs[1] - MC1 * xs[7] - MS3 * xs[3] + MC3 * xs[5];
    for (int n = 0; n < 4; n++) begin
      g[n]     = e[n] + o[n];
      g[7 - n] = e[n] - o[n];
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_out
      assign y[gi] = OW'((g[gi] + RND) >>> SHIFT);
    end
  endgenerate
endmodule

// File: rtl/loeffler2d_idct.sv
// Four-stage pipelined 8x8 2D IDCT (input reg, row pass, column pass, round/clamp), one block per cycle.
// IDCT_CLAMP_EN saturates outputs to [-128,127]; otherwise the rounded result wraps to 8 bits.
module loeffler2d_idct
  import idct_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [7:0][7:0][11:0] idct_in,
  output logic [7:0][7:0][7:0]  idct_out,
  output logic                  valid_out
);
  coef_blk_t in_reg;
  mid_blk_t  row_reg, row_next;
  acc_blk_t  col_reg, col_next;
  pix_blk_t  out_next;
  logic [3:0] valid_reg;

  logic [7:0][7:0][MID_W-1:0] col_in;   // [x][v]
  logic [7:0][7:0][ACC_W-1:0] col_res;  // [x][y]

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_row
      loeffler1d_idct #(.IW(COEF_W), .OW(MID_W), .SHIFT(ROW_SHIFT)) u_row (
        .x(in_reg[gi]),
        .y(row_next[gi])
      );
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_col
      for (genvar gj = 0; gj < 8; gj++) begin : g_tr
        assign col_in[gi][gj]   = row_reg[gj][gi];
        assign col_next[gj][gi] = col_res[gi][gj];
      end
      loeffler1d_idct #(.IW(MID_W), .OW(ACC_W), .SHIFT(0)) u_col (
        .x(col_in[gi]),
        .y(col_res[gi])
      );
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_rnd_y
      for (genvar gj = 0; gj < 8; gj++) begin : g_rnd_x
        assign out_next[gi][gj] = round_pix(col_reg[gi][gj]);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reg    <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      idct_out  <= '0;
      valid_reg <= '0;
    end else begin
      in_reg    <= idct_in;
      row_reg   <= row_next;
      col_reg   <= col_next;
      idct_out  <= out_next;
      valid_reg <= {valid_reg[2:0], valid_in};
    end
  end

  assign valid_out = valid_reg[3];
endmodule

// File: tb/tb_loeffler2d_idct.sv
// Scoreboard bench for loeffler2d_idct: directed DC/AC/saturation blocks, random blocks against a
// double-precision model, valid_out vs valid_in delayed four cycles, and reset with blocks in flight.
module tb_loeffler2d_idct;
  logic                  clk = 1'b0;
  logic                  rst;
  logic                  valid_in;
  logic [7:0][7:0][11:0] idct_in;
  logic [7:0][7:0][7:0]  idct_out;
  logic                  valid_out;

  loeffler2d_idct dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .idct_in  (idct_in),
    .idct_out (idct_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    px[64];
    int    tol;
    int    id;
    string name;
  } exp_t;

  exp_t   exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     blk_id = 0;
  int     cf[8][8];
  real    ct[8][8];
  logic [3:0] vhist;

`ifdef IDCT_CLAMP_EN
  localparam bit CLAMP = 1'b1;
  localparam int DC_POS_EXP = 127;
  localparam int DC_NEG_EXP = -128;
`else
  localparam bit CLAMP = 1'b0;
  localparam int DC_POS_EXP = -128;
  localparam int DC_NEG_EXP = 0;
`endif

  function automatic int round_away(real f);
    if (f >= 0.0) return int'($floor(f + 0.5));
    else return -int'($floor(-f + 0.5));
  endfunction

  function automatic int fit8(int r);
    byte b;
    if (CLAMP) return (r > 127) ? 127 : ((r < -128) ? -128 : r);
    b = byte'(r);
    return int'(b);
  endfunction

  task automatic clear_cf();
    for (int v = 0; v < 8; v++)
      for (int u = 0; u < 8; u++) cf[v][u] = 0;
  endtask

  task automatic drive(input exp_t e);
    for (int v = 0; v < 8; v++)
      for (int u = 0; u < 8; u++) idct_in[v][u] = 12'(cf[v][u]);
    valid_in = 1'b1;
    e.id = blk_id;
    blk_id++;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic send_same(input int val, input string name);
    exp_t e;
    for (int i = 0; i < 64; i++) e.px[i] = val;
    e.tol = 0;
    e.name = name;
    drive(e);
  endtask

  task automatic send_row(input int ex[8], input string name);
    exp_t e;
    for (int i = 0; i < 64; i++) e.px[i] = ex[i % 8];
    e.tol = 0;
    e.name = name;
    drive(e);
  endtask

  task automatic send_model(input string name);
    exp_t e;
    real  s, cv, cu;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        s = 0.0;
        for (int v = 0; v < 8; v++)
          for (int u = 0; u < 8; u++) begin
            cv = (v == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            s += cv * cu * real'(cf[v][u]) * ct[y][v] * ct[x][u];
          end
        e.px[y*8+x] = fit8(round_away(s / 4.0));
      end
    e.tol = 1;
    e.name = name;
    drive(e);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int v = 0; v < 8; v++)
      for (int u = 0; u < 8; u++) idct_in[v][u] = 12'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid: got %b expected 0", name, valid_out);
    end
    checks++;
    if (idct_out !== '0) begin
      errors++;
      $display("FAIL %s_data: got %h expected 0", name, idct_out);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending blocks expected 0", exp_q.size());
    end
  endtask

  // Sampled valid_in history, cleared together with the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) vhist <= '0;
    else vhist <= {vhist[2:0], valid_in};
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (valid_out !== vhist[3]) begin
        errors++;
        $display("FAIL valid_delay: got %b expected %b", valid_out, vhist[3]);
      end
      if (valid_out === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_block: got valid_out=1 expected no block");
        end else begin
          exp_t e;
          int   bad, got;
          byte  d;
          e = exp_q.pop_front();
          bad = -1;
          got = 0;
          for (int i = 0; i < 64; i++) begin
            got = int'($signed(idct_out[i/8][i%8]));
            d = byte'(got - e.px[i]);
            if (bad < 0 && (d > e.tol || d < -e.tol)) bad = i;
          end
          if (bad >= 0) begin
            errors++;
            $display("FAIL blk %0d %s y=%0d x=%0d: got %0d expected %0d (tol %0d)", e.id, e.name,
                     bad / 8, bad % 8, int'($signed(idct_out[bad/8][bad%8])), e.px[bad], e.tol);
          end else begin
            $display("blk %0d %s ok", e.id, e.name);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ac_row[8] = '{14, 12, 8, 3, -3, -8, -12, -14};
    int m;
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 8; k++) ct[n][k] = $cos(real'((2 * n + 1) * k) * 3.141592653589793 / 16.0);

    rst = 1'b1;
    valid_in = 1'b0;
    idct_in = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    clear_cf();
    repeat (4) send_same(0, "zero");
    cf[0][0] = 8;    send_same(1, "dc8");
    cf[0][0] = -400; send_same(-50, "dc-400");
    idle(2);
    cf[0][0] = 1023;  send_same(DC_POS_EXP, "dc1023");
    cf[0][0] = -2048; send_same(DC_NEG_EXP, "dc-2048");
    idle(1);
    clear_cf();
    cf[0][1] = 80;
    send_row(ac_row, "ac01_80");
    idle(1);

    for (int b = 0; b < 16; b++) begin
      for (int v = 0; v < 8; v++)
        for (int u = 0; u < 8; u++) begin
          m = (v == 0 && u == 0) ? 1000 : (120 >> ((v + u) / 2));
          cf[v][u] = int'($urandom_range(0, 2 * m)) - m;
        end
      send_model("rand");
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);
    drain();

    // Reset with the first of four blocks on the output and three still in flight.
    clear_cf();
    cf[0][0] = 8;
    repeat (4) send_same(1, "pre_rst");
    #2;
    valid_in = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    clear_cf();
    cf[0][0] = -400;
    send_same(-50, "post_rst");
    idle(1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
